// File: rtl/lsu_pkg.sv
// Shared encodings and address helpers for the load/store unit.
// Optional misalignment trapping is selected with the LSU_MISALIGN_TRAP_EN macro.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } lsu_state_e;

    // Encoding 3 is folded onto word so downstream logic only sees three sizes.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        logic [1:0] r;
        r = (size == SZ_BYTE || size == SZ_HALF) ? size : SZ_WORD;
        return r;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic r;
        case (norm_size(size))
            SZ_HALF: r = lo[0];
            SZ_WORD: r = |lo;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        logic [1:0] r;
        case (norm_size(size))
            SZ_BYTE: r = lo;
            SZ_HALF: r = {lo[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane steering: merges store data into an old word and
// extracts/extends a load lane from a read word. Purely combinational.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] st_old_i,
    input  logic [31:0] st_data_i,
    input  logic [1:0]  st_lo_i,
    input  logic [1:0]  st_size_i,
    output logic [31:0] st_word_o,
    input  logic [31:0] ld_word_i,
    input  logic [1:0]  ld_lo_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_unsigned_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sext;

    always_comb begin
        st_word_o = st_old_i;
        case (st_size_i)
            SZ_BYTE: st_word_o[{st_lo_i, 3'b000} +: 8]     = st_data_i[7:0];
            SZ_HALF: st_word_o[{st_lo_i[1], 4'b0000} +: 16] = st_data_i[15:0];
            default: st_word_o = st_data_i;
        endcase
    end

    assign ld_byte = ld_word_i[{ld_lo_i, 3'b000} +: 8];
    assign ld_half = ld_word_i[{ld_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_sext   = 1'b0;
        ld_data_o = ld_word_i;
        case (ld_size_i)
            SZ_BYTE: begin
                ld_sext   = ~ld_unsigned_i & ld_byte[7];
                ld_data_o = {{24{ld_sext}}, ld_byte};
            end
            SZ_HALF: begin
                ld_sext   = ~ld_unsigned_i & ld_half[15];
                ld_data_o = {{16{ld_sext}}, ld_half};
            end
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide data memory; sub-word
// stores use read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int BA_W = MEM_AW + 2;

    lsu_state_e        state_q, state_d;
    logic [BA_W-1:0]   addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic [1:0]        req_sz;
    logic              mis;
    logic [BA_W-1:0]   req_ba;
    logic              accept;
    logic [DATA_W-1:0] st_word;
    logic [DATA_W-1:0] ld_data;
    logic              unused_addr_hi;

    assign req_sz = norm_size(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis    = is_misaligned(req_sz, req_addr[1:0]);
    assign req_ba = req_addr[BA_W-1:0];
`else
    assign mis    = 1'b0;
    assign req_ba = {req_addr[BA_W-1:2], align_lo(req_sz, req_addr[1:0])};
`endif

    // Address bits above the memory window are deliberately ignored (wrap).
    assign unused_addr_hi = ^req_addr[31:BA_W];

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready && !rst;

    lsu_byte_lane u_lane (
        .st_old_i      (mem_dout),
        .st_data_i     (wdata_q),
        .st_lo_i       (addr_q[1:0]),
        .st_size_i     (size_q),
        .st_word_o     (st_word),
        .ld_word_i     (mem_dout),
        .ld_lo_i       (req_ba[1:0]),
        .ld_size_i     (req_sz),
        .ld_unsigned_i (req_unsigned),
        .ld_data_o     (ld_data)
    );

    // Memory strobes are combinational so loads and word stores finish in one cycle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_din   = req_wdata;
        mem_addr[MEM_AW-1:0] = req_ba[BA_W-1:2];
        case (state_q)
            IDLE: begin
                if (accept && !mis) begin
                    mem_read  = !req_write;
                    mem_write = req_write && (req_sz == SZ_WORD);
                end
            end
            RMW_RD: begin
                mem_read = !rst;
                mem_addr[MEM_AW-1:0] = addr_q[BA_W-1:2];
            end
            RMW_WR: begin
                mem_write = !rst;
                mem_addr[MEM_AW-1:0] = addr_q[BA_W-1:2];
                mem_din   = merge_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    resp_valid_d = 1'b1;
                    if (mis) begin
                        resp_err_d = 1'b1;
                    end else if (!req_write) begin
                        resp_rdata_d = ld_data;
                    end else if (req_sz != SZ_WORD) begin
                        resp_valid_d = 1'b0;
                        state_d      = RMW_RD;
                        addr_d       = req_ba;
                        size_d       = req_sz;
                        wdata_d      = req_wdata;
                    end
                end
            end
            RMW_RD: begin
                merge_d = st_word;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Captured request fields are only meaningful inside an RMW, so they carry no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        size_q  <= size_d;
        wdata_q <= wdata_d;
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic against a byte-array reference model of memory.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_din, mem_dout;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic mem_init = 1'b1;

    logic [31:0] dmem [0:1023];
    logic [7:0]  ref_mem [0:4095];

    load_store_unit #(.MEM_AW(10), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // Word-wide data memory with asynchronous read, as seen by the unit.
    assign mem_dout = dmem[mem_addr[9:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= init_word(i);
        end else if (mem_write) begin
            dmem[mem_addr[9:0]] <= mem_din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Reference model: byte-addressed memory of 4 KiB, addresses wrap.
    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_mis(input logic [31:0] a, input logic [1:0] sz);
        return (nbytes(sz) == 2 && (a % 2) != 0) || (nbytes(sz) == 4 && (a % 4) != 0);
    endfunction

    function automatic int unsigned ref_base(input logic [31:0] a, input logic [1:0] sz);
        int unsigned b;
        b = a % 4096;
        b = b - (b % nbytes(sz));
        return b;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
        int unsigned b, n, v;
        b = ref_base(a, sz);
        n = nbytes(sz);
        v = 0;
        for (int k = 0; k < 4; k++) if (k < n) v = v + (int'(ref_mem[b + k]) << (8 * k));
        if (!u && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int unsigned b;
        b = ref_base(a, sz);
        for (int k = 0; k < 4; k++) if (k < nbytes(sz)) ref_mem[b + k] = 8'((d >> (8 * k)) & 32'hFF);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = u; req_addr = a; req_wdata = d;
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] b2b_addr [4];
        logic [1:0]  b2b_size [4];
        logic        b2b_uns  [4];
        logic [31:0] b2b_exp  [4];
        int wr0, n;
        logic        w, u, mis;
        logic [1:0]  sz;
        logic [31:0] a, d, exp_data;

        b2b_addr = '{32'h11, 32'h12, 32'h13, 32'h12};
        b2b_size = '{2'd0, 2'd0, 2'd0, 2'd1};
        b2b_uns  = '{1'b0, 1'b0, 1'b1, 1'b0};
        b2b_exp  = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF};

        for (int i = 0; i < 1024; i++)
            for (int k = 0; k < 4; k++) ref_mem[4 * i + k] = 8'((init_word(i) >> (8 * k)) & 32'hFF);

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        tick(); tick();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        mem_init = 1'b0;
        rst = 1'b0;
        tick();

        // Word store then word load.
        drive(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01);
        check("sw_mem_write", 32'(mem_write), 32'd1);
        check("sw_mem_read", 32'(mem_read), 32'd0);
        check("sw_mem_addr", mem_addr, 32'd4);
        check("sw_mem_din", mem_din, 32'h80FF7F01);
        ref_store(32'h10, 2'd2, 32'h80FF7F01);
        tick(); idle();
        check("sw_resp_valid", 32'(resp_valid), 32'd1);
        check("sw_resp_rdata", resp_rdata, 32'd0);
        check("sw_write_once", 32'(mem_write), 32'd0);

        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw_mem_read", 32'(mem_read), 32'd1);
        check("lw_mem_addr", mem_addr, 32'd4);
        tick();
        check("lw_resp_valid", 32'(resp_valid), 32'd1);
        check("lw_resp_rdata", resp_rdata, 32'h80FF7F01);

        // Back-to-back sub-word loads, one per cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, b2b_size[i], b2b_uns[i], b2b_addr[i], 32'h0);
            check("b2b_ready", 32'(req_ready), 32'd1);
            tick();
            check("b2b_resp_valid", 32'(resp_valid), 32'd1);
            check("b2b_rdata", resp_rdata, b2b_exp[i]);
            check("b2b_ref", resp_rdata, ref_load(b2b_addr[i], b2b_size[i], b2b_uns[i]));
        end
        idle();

        // Byte store via read-modify-write.
        wr0 = wr_cnt;
        drive(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB);
        check("sb_accept_no_write", 32'(mem_write), 32'd0);
        ref_store(32'h11, 2'd0, 32'h000000AB);
        tick(); idle();
        check("sb_rd_ready", 32'(req_ready), 32'd0);
        check("sb_rd_mem_read", 32'(mem_read), 32'd1);
        check("sb_rd_mem_addr", mem_addr, 32'd4);
        check("sb_rd_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        check("sb_wr_ready", 32'(req_ready), 32'd0);
        check("sb_wr_mem_write", 32'(mem_write), 32'd1);
        check("sb_wr_mem_din", mem_din, 32'h80FFAB01);
        check("sb_wr_mem_addr", mem_addr, 32'd4);
        check("sb_wr_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        check("sb_resp_valid", 32'(resp_valid), 32'd1);
        check("sb_ready_back", 32'(req_ready), 32'd1);
        check("sb_write_count", 32'(wr_cnt - wr0), 32'd1);
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        tick(); idle();
        check("sb_readback", resp_rdata, 32'h80FFAB01);

        // Reset during RMW_RD abandons the store.
        wr0 = wr_cnt;
        drive(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234);
        tick(); idle();
        check("abort_in_rmw", 32'(req_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        tick(); tick();
        check("abort_no_resp", 32'(resp_valid), 32'd0);
        check("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        tick(); idle();
        check("abort_mem_unchanged", resp_rdata, 32'h80FFAB01);

        // Misaligned halfword load.
        drive(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_mem_read", 32'(mem_read), 32'd0);
        check("mis_mem_write", 32'(mem_write), 32'd0);
        tick(); idle();
        check("mis_resp_valid", 32'(resp_valid), 32'd1);
        check("mis_resp_err", 32'(resp_err), 32'd1);
        check("mis_resp_rdata", resp_rdata, 32'd0);
`else
        check("mis_mem_read", 32'(mem_read), 32'd1);
        check("mis_mem_addr", mem_addr, 32'd4);
        tick(); idle();
        check("mis_resp_valid", 32'(resp_valid), 32'd1);
        check("mis_resp_err", 32'(resp_err), 32'd0);
        check("mis_resp_rdata", resp_rdata, 32'hFFFFAB01);
`endif

        // Address wrap above the memory window.
        drive(1'b0, 2'd2, 1'b0, 32'h1010, 32'h0);
        check("wrap_mem_addr", mem_addr, 32'd4);
        tick(); idle();
        check("wrap_rdata", resp_rdata, 32'h80FFAB01);

        // Random traffic against the reference model.
        for (int t = 0; t < 300; t++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            a  = $urandom & 32'hFFFF_F03F;
            d  = $urandom;
            mis = TRAP && ref_mis(a, sz);
            exp_data = (mis || w) ? 32'd0 : ref_load(a, sz, u);
            wr0 = wr_cnt;
            drive(w, sz, u, a, d);
            if (w && !mis) ref_store(a, sz, d);
            tick(); idle();
            n = 0;
            while (!resp_valid && n < 6) begin
                tick();
                n++;
            end
            check("rnd_resp_valid", 32'(resp_valid), 32'd1);
            check("rnd_resp_rdata", resp_rdata, exp_data);
            check("rnd_resp_err", 32'(resp_err), 32'(mis));
            check("rnd_write_count", 32'(wr_cnt - wr0), 32'(w && !mis));
            tick();
            check("rnd_resp_pulse", 32'(resp_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and data_memory; converts byte-addressed load/store requests into word-indexed memory accesses.
- Handles byte/halfword/word sizes with a sign- or zero-extended load result.
- Performs sub-word stores as a two-cycle read-modify-write on the word-wide memory.
- Exposes a valid/ready request handshake and a one-cycle response pulse to the pipeline.

Parameters:
- MEM_AW, 10: width of the memory word index; upper byte-address bits beyond MEM_AW+2 are ignored, so addresses wrap.
- DATA_W, 32: data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; equals (state==IDLE).
- req_write  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3 treated as word.
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse on completion.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misalignment flag, valid with resp_valid.
- mem_read  out  1  to data_memory mem_read.
- mem_write  out  1  to data_memory mem_write.
- mem_addr  out  32  word index {zeros, byte_addr[MEM_AW+1:2]}.
- mem_din  out  32  write data.
- mem_dout  in  32  asynchronous read data from data_memory.

Behaviour:
- States: IDLE, RMW_RD, RMW_WR.
- Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, merge register=0. mem_read and mem_write are 0 whenever no access is in progress.
- Accept condition: req_valid && req_ready.
- Load (accept cycle, IDLE): mem_read=1 combinationally; mem_addr is taken from req_addr. The selected lane of mem_dout is extracted and extended into resp_rdata. resp_valid=1 in the next cycle. The unit stays in IDLE, so back-to-back loads run at 1 per cycle.
- Lane selection (little-endian): byte lane = addr[1:0]; half lane = addr[1].
- Word store (accept cycle): mem_write=1, mem_din=req_wdata; resp_valid next cycle; stays in IDLE.
- Sub-word store: accept captures addr, size, wdata and goes to RMW_RD.
  - RMW_RD: mem_read=1 at the captured address; mem_dout merged with the byte/half lane is registered; go to RMW_WR.
  - RMW_WR: mem_write=1, mem_din=merged word; go to IDLE and set resp_valid next cycle.
  - Accept-to-resp_valid latency is 3 cycles. req_ready=0 in RMW_RD and RMW_WR.
- mem_write is high for exactly one cycle per store. mem_addr/mem_din are stable in every write cycle.
- No response backpressure: the consumer must take resp_valid when it is asserted.
- rst in any state returns to IDLE immediately. An in-flight RMW is abandoned with no mem_write and no resp_valid.
- Simultaneous resp_valid and new accept in IDLE is legal.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: half with addr[0]=1, or word with addr[1:0]!=0, performs no memory access (mem_read=mem_write=0). resp_valid comes next cycle with resp_err=1 and resp_rdata=0.
- Undefined: low address bits are force-aligned (half clears bit0, word clears bits[1:0]); resp_err tied 0.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state enum IDLE/RMW_RD/RMW_WR;
  - misalign-check function.
- One combinational sub-module lsu_byte_lane:
  - store merge (old word, data, addr[1:0], size → new word);
  - load extract/extend (word, addr[1:0], size, unsigned → result).

Test Plan:
- Word store 0x80FF7F01 to 0x10, then LW 0x10 → mem_addr=4, mem_write one cycle; resp_rdata=0x80FF7F01 one cycle after accept.
- Same word: LB 0x11 → 0x0000007F; LB 0x12 → 0xFFFFFFFF; LBU 0x13 → 0x00000080; LH 0x12 → 0xFFFF80FF. Issue back-to-back, one per cycle, with req_ready held at 1.
- SB 0xAB to 0x11 → req_ready low 2 cycles, single mem_write with mem_din=0x80FFAB01, resp_valid 3 cycles after accept; a following LW returns 0x80FFAB01.
- Assert rst during RMW_RD of SH 0x1234 to 0x12 → no mem_write, state IDLE, resp_valid stays 0; memory unchanged.
- LH 0x11:
  - with LSU_MISALIGN_TRAP_EN: no mem access, resp_err=1, resp_rdata=0;
  - without it: reads lane for 0x10, returning 0xFFFFAB01.
- Address 0x1010 with MEM_AW=10 → mem_addr=4 (wrap); its data matches that of address 0x10.
